// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction scheduler: FSM encoding and default parameters.
package spi_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_GAP_CYC = 4;
    localparam int unsigned DEF_TMO_CYC = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_rr_arb.sv
// Two-way round-robin arbiter; remembers the last served requester and favours the other on contention.
module spi_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last,
    output logic       winner
);

    logic ptr;

    // ptr holds the index served last; resetting it to 1 makes requester 0 win first
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b1;
        end else if (update) begin
            ptr <= last;
        end
    end

    always_comb begin
        winner = (&req) ? ~ptr : req[1];
    end

endmodule

// File: rtl/spi_sched.sv
// Schedules SPI transactions for two requesters: round-robin grant, wait for completion or timeout, enforce idle gap.
module spi_sched
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC,
    parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] tx0,
    input  logic [DATA_W-1:0] tx1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rx0,
    output logic [DATA_W-1:0] rx1,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_tx,
    output logic              spi_sel,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rx,
    output logic              err
);

    localparam int unsigned TW = (TMO_CYC >= 1024) ? $clog2(TMO_CYC + 1) : 10;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t            state, state_n;
    logic [TW-1:0]     tmo_cnt, tmo_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic [1:0]        gnt, gnt_n;
    logic [1:0]        done, done_n;
    logic              start_n, err_n, sel_n;
    logic [DATA_W-1:0] tx_n, rx0_n, rx1_n;
    logic              update, winner;

    spi_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (update),
        .last   (winner),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            done      <= '0;
            spi_start <= 1'b0;
            err       <= 1'b0;
            spi_sel   <= 1'b0;
            spi_tx    <= '0;
            rx0       <= '0;
            rx1       <= '0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= tmo_n;
            gap_cnt   <= gap_n;
            gnt       <= gnt_n;
            done      <= done_n;
            spi_start <= start_n;
            err       <= err_n;
            spi_sel   <= sel_n;
            spi_tx    <= tx_n;
            rx0       <= rx0_n;
            rx1       <= rx1_n;
        end
    end

    // Every pulse output is computed here and registered above, so none is combinational from inputs
    always_comb begin
        state_n = state;
        tmo_n   = tmo_cnt;
        gap_n   = gap_cnt;
        gnt_n   = '0;
        done_n  = '0;
        start_n = 1'b0;
        err_n   = 1'b0;
        sel_n   = spi_sel;
        tx_n    = spi_tx;
        rx0_n   = rx0;
        rx1_n   = rx1;
        update  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    update  = 1'b1;
                    sel_n   = winner;
                    tx_n    = winner ? tx1 : tx0;
                    gnt_n   = {winner, ~winner};
                    start_n = 1'b1;
                    tmo_n   = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // completion takes priority over a timeout in the same cycle
                if (spi_done) begin
                    if (spi_sel) rx1_n = spi_rx;
                    else         rx0_n = spi_rx;
                    done_n  = {spi_sel, ~spi_sel};
                    gap_n   = '0;
                    state_n = GAP;
                end else if (tmo_cnt == TW'(TMO_CYC)) begin
                    err_n   = 1'b1;
                    done_n  = {spi_sel, ~spi_sel};
                    gap_n   = '0;
                    state_n = GAP;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign gnt0  = gnt[0];
    assign gnt1  = gnt[1];
    assign done0 = done[0];
    assign done1 = done[1];

endmodule

// File: tb/tb_spi_sched.sv
// Self-checking bench for spi_sched: transaction-level reference model of arbitration, timing and rx storage.
module tb_spi_sched;

    localparam int DW  = 16;
    localparam int GAP = 4;
    localparam int TMO = 1023;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DW-1:0] tx0 = '0, tx1 = '0;
    logic          gnt0, gnt1, done0, done1, spi_start, spi_sel, err;
    logic [DW-1:0] rx0, rx1, spi_tx;
    logic          spi_done = 1'b0;
    logic [DW-1:0] spi_rx = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reference model state
    int            last_served;
    int            last_done;
    logic [DW-1:0] m_rx0, m_rx1, m_tx;
    logic          m_sel;

    spi_sched #(.DATA_W(DW), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .tx0       (tx0),
        .tx1       (tx1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rx0       (rx0),
        .rx1       (rx1),
        .spi_start (spi_start),
        .spi_tx    (spi_tx),
        .spi_sel   (spi_sel),
        .spi_done  (spi_done),
        .spi_rx    (spi_rx),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return (last_served == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; spi_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_served = 1;
        last_done   = -1000;
        m_rx0 = '0; m_rx1 = '0; m_tx = '0; m_sel = 1'b0;
    endtask

    task automatic end_reqs();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // One transaction: request, check grant timing and fields, then complete (or time out) and check done/rx.
    task automatic do_txn(input bit r0, input bit r1, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input int dly, input bit timeout, input logic [DW-1:0] rxw, output int sel_o);
        int c0, g, w, exp_g;
        bit got;
        logic [1:0] exp_gnt;
        logic [DW-1:0] exp_word;
        c0 = cyc;
        req0 = r0; req1 = r1; tx0 = w0; tx1 = w1;
        w = pick(r0, r1);
        sel_o = -1;
        exp_gnt  = (w == 1) ? 2'b10 : 2'b01;
        exp_word = (w == 1) ? w1 : w0;
        exp_g = (c0 + 1 > last_done + GAP + 1) ? c0 + 1 : last_done + GAP + 1;
        got = 1'b0;
        for (int i = 0; i < 4 * GAP + 8; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin got = 1'b1; break; end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL grant_wait: no grant seen, required grant %b", exp_gnt);
            end_reqs();
            return;
        end
        g = cyc;
        sel_o = int'(spi_sel);
        vectors++;
        if (g !== exp_g) begin
            miscompares++;
            $display("FAIL grant_cycle: got cycle %0d, required %0d", g, exp_g);
        end
        vectors++;
        if ({gnt1, gnt0, spi_start, spi_sel, spi_tx} !== {exp_gnt, 1'b1, w[0], exp_word}) begin
            miscompares++;
            $display("FAIL grant_fields: gnt=%b start=%b sel=%b tx=%h, required gnt=%b start=1 sel=%0d tx=%h",
                     {gnt1, gnt0}, spi_start, spi_sel, spi_tx, exp_gnt, w, exp_word);
        end
        last_served = w;
        m_tx  = exp_word;
        m_sel = w[0];
        if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({gnt1, gnt0, spi_start} !== 3'b000) begin
            miscompares++;
            $display("FAIL grant_pulse: gnt=%b start=%b one cycle later, required 00/0", {gnt1, gnt0}, spi_start);
        end
        if (!timeout) begin
            repeat (dly) @(negedge clk);
            spi_done = 1'b1; spi_rx = rxw;
            @(negedge clk);
            spi_done = 1'b0; spi_rx = DW'($urandom);
            if (w == 0) m_rx0 = rxw; else m_rx1 = rxw;
            vectors++;
            if ({done1, done0, err} !== {exp_gnt, 1'b0}) begin
                miscompares++;
                $display("FAIL done_pulse: done=%b err=%b, required done=%b err=0", {done1, done0}, err, exp_gnt);
            end
        end else begin
            got = 1'b0;
            for (int i = 0; i < TMO + 8; i++) begin
                @(negedge clk);
                if (done0 || done1 || err) begin got = 1'b1; break; end
            end
            vectors++;
            if (!got || cyc !== g + TMO + 1) begin
                miscompares++;
                $display("FAIL timeout_cycle: got=%0d cycle %0d, required cycle %0d", got, cyc, g + TMO + 1);
            end
            vectors++;
            if ({done1, done0, err} !== {exp_gnt, 1'b1}) begin
                miscompares++;
                $display("FAIL timeout_pulse: done=%b err=%b, required done=%b err=1", {done1, done0}, err, exp_gnt);
            end
        end
        last_done = cyc;
        vectors++;
        if ({rx1, rx0, spi_tx} !== {m_rx1, m_rx0, exp_word}) begin
            miscompares++;
            $display("FAIL rx_store: rx1=%h rx0=%h tx=%h, required rx1=%h rx0=%h tx=%h",
                     rx1, rx0, spi_tx, m_rx1, m_rx0, exp_word);
        end
        @(negedge clk);
        vectors++;
        if ({done1, done0, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL done_width: done=%b err=%b after one cycle, required 00/0", {done1, done0}, err);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({gnt1, gnt0, done1, done0, spi_start, err, spi_sel, spi_tx, rx0, rx1} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: gnt=%b done=%b start=%b err=%b sel=%b tx=%h rx0=%h rx1=%h, required all 0",
                     {gnt1, gnt0}, {done1, done0}, spi_start, err, spi_sel, spi_tx, rx0, rx1);
        end
    endtask

    task automatic test_single();
        int s;
        do_txn(1'b1, 1'b0, 16'hA5C3, DW'($urandom), 2, 1'b0, DW'($urandom), s);
        end_reqs();
    endtask

    task automatic test_back_to_back();
        int s;
        int seq[4];
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, DW'($urandom), DW'($urandom), $urandom_range(0, 3), 1'b0, DW'($urandom), s);
            seq[i] = s;
        end
        end_reqs();
        vectors++;
        if (seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
            miscompares++;
            $display("FAIL rr_order: served %0d,%0d,%0d,%0d, required 0,1,0,1", seq[0], seq[1], seq[2], seq[3]);
        end
    endtask

    task automatic test_rx1();
        int s;
        do_txn(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1, 1'b0, 16'h1234, s);
        end_reqs();
    endtask

    task automatic test_timeout();
        int s;
        do_txn(1'b1, 1'b0, DW'($urandom), DW'($urandom), 0, 1'b1, '0, s);
        do_txn(1'b0, 1'b1, DW'($urandom), DW'($urandom), 0, 1'b0, DW'($urandom), s);
        end_reqs();
    endtask

    task automatic test_done_at_timeout();
        int s;
        do_txn(1'b0, 1'b1, DW'($urandom), DW'($urandom), TMO - 1, 1'b0, DW'($urandom), s);
        end_reqs();
    endtask

    task automatic test_stray_done();
        repeat (GAP + 3) @(negedge clk);
        spi_done = 1'b1; spi_rx = DW'($urandom);
        @(negedge clk);
        spi_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({gnt1, gnt0, done1, done0, spi_start, err, spi_sel, spi_tx, rx0, rx1} !==
                {4'b0000, 2'b00, m_sel, m_tx, m_rx0, m_rx1}) begin
                miscompares++;
                $display("FAIL stray_done: done=%b err=%b sel=%b tx=%h rx0=%h rx1=%h, required done=00 err=0 sel=%b tx=%h rx0=%h rx1=%h",
                         {done1, done0}, err, spi_sel, spi_tx, rx0, rx1, m_sel, m_tx, m_rx0, m_rx1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_wait();
        bit got;
        req1 = 1'b1; tx1 = DW'($urandom);
        got = 1'b0;
        for (int i = 0; i < 4 * GAP + 8; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin got = 1'b1; break; end
        end
        end_reqs();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL rst_wait_grant: no grant seen, required a grant");
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_served = 1; last_done = -1000;
        m_rx0 = '0; m_rx1 = '0; m_tx = '0; m_sel = 1'b0;
        spi_done = 1'b1; spi_rx = DW'($urandom);
        @(negedge clk);
        spi_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({gnt1, gnt0, done1, done0, spi_start, err, spi_sel, spi_tx, rx0, rx1} !== '0) begin
                miscompares++;
                $display("FAIL rst_in_wait: gnt=%b done=%b start=%b err=%b sel=%b tx=%h rx0=%h rx1=%h, required all 0",
                         {gnt1, gnt0}, {done1, done0}, spi_start, err, spi_sel, spi_tx, rx0, rx1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int s, pat;
        for (int i = 0; i < 16; i++) begin
            pat = $urandom_range(1, 3);
            do_txn(pat[0], pat[1], DW'($urandom), DW'($urandom), $urandom_range(0, 8), 1'b0, DW'($urandom), s);
            if ($urandom_range(0, 2) == 0) begin
                end_reqs();
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        end_reqs();
    endtask

    initial begin
        reset_dut();
        test_reset();
        test_single();
        reset_dut();
        test_back_to_back();
        test_rx1();
        test_stray_done();
        test_timeout();
        test_done_at_timeout();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
